delta_pattern_detector: RTL and testbench

- Inverse of the pattern counter: watches a stream of 12-bit sample values and infers the constant step between consecutive samples (0, 1, 4 or 8).
- Reports the step as a 2-bit Xmode code plus a base value (the last accepted sample).
- When the counter is fed with these outputs as Xmode/LoadVal, its output predicts the next sample.
- Sits upstream of the counter, in the pattern-analysis path; declares lock after a programmable number of consistent steps.

---
 rtl/delta_pattern_detector.sv | 181 ++++++++++++++++++
 tb/tb_delta_pattern_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/delta_pattern_detector.sv
// rtl/delta_pattern_detector.sv - infers a constant 0/1/4/8 step in a sample stream
//
// Purpose: watches accepted samples, classifies the delta between consecutive
// samples and reports it as an Xmode code plus base value, so a downstream
// pattern counter loaded with Xmode/base predicts the next sample.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous reset, active-high (asserted = 1)
//   restart    - synchronous history clear, below rst_n in priority
//   sample_vld - sample qualifier
//   sample     - incoming W-bit sample
//   Xmode      - detected step code: 00=0, 01=1, 10=4, 11=8
//   base       - last accepted sample
//   pred       - base + step, mod 2^W
//   locked     - pattern locked
//   mismatch   - one-cycle pulse when a locked pattern breaks
//   run_len    - consecutive matching deltas, saturating
module delta_pattern_detector #(
    parameter int W        = 12,
    parameter int LOCK_CNT = 3,
    parameter int RUN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             sample_vld,
    input  logic [W-1:0]     sample,
    output logic [1:0]       Xmode,
    output logic [W-1:0]     base,
    output logic [W-1:0]     pred,
    output logic             locked,
    output logic             mismatch,
    output logic [RUN_W-1:0] run_len
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] LOCK_THR = RUN_W'(LOCK_CNT);
    // With a lock count of one, the very first classified delta already locks.
    localparam bit               LOCK_NOW = (LOCK_CNT <= 1);

    state_t           state, state_nxt;
    logic [1:0]       xmode_nxt;
    logic [W-1:0]     base_nxt;
    logic             locked_nxt;
    logic             mismatch_nxt;
    logic [RUN_W-1:0] run_nxt;

    logic [W-1:0]     diff;
    logic             classified;
    logic [1:0]       code;
    logic [RUN_W-1:0] run_inc;
    logic             same_step;

    function automatic logic [W-1:0] step_of(input logic [1:0] c);
        case (c)
            2'b00:   step_of = W'(0);
            2'b01:   step_of = W'(1);
            2'b10:   step_of = W'(4);
            default: step_of = W'(8);
        endcase
    endfunction

    // Modular subtraction makes wrap-around steps (e.g. 4095 -> 0) classify normally.
    assign diff      = sample - base;
    assign run_inc   = (run_len == RUN_MAX) ? run_len : run_len + RUN_W'(1);
    assign same_step = classified && (code == Xmode);

    always_comb begin
        classified = 1'b1;
        code       = 2'b00;
        case (diff)
            W'(0):   code = 2'b00;
            W'(1):   code = 2'b01;
            W'(4):   code = 2'b10;
            W'(8):   code = 2'b11;
            default: classified = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        xmode_nxt    = Xmode;
        base_nxt     = base;
        locked_nxt   = locked;
        mismatch_nxt = 1'b0;
        run_nxt      = run_len;

        if (restart) begin
            locked_nxt = 1'b0;
            run_nxt    = '0;
            xmode_nxt  = 2'b00;
            if (sample_vld) begin
                base_nxt  = sample;
                state_nxt = FIRST;
            end else begin
                state_nxt = EMPTY;
            end
        end else if (sample_vld) begin
            base_nxt = sample;
            case (state)
                EMPTY: begin
                    state_nxt = FIRST;
                end
                FIRST: begin
                    if (classified) begin
                        xmode_nxt = code;
                        run_nxt   = RUN_W'(1);
                        if (LOCK_NOW) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                        end else begin
                            state_nxt = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (same_step) begin
                        run_nxt = run_inc;
                        if (run_inc >= LOCK_THR) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end else if (classified) begin
                        xmode_nxt = code;
                        run_nxt   = RUN_W'(1);
                    end else begin
                        run_nxt   = '0;
                        state_nxt = FIRST;
                    end
                end
                LOCKED: begin
                    if (same_step) begin
                        run_nxt = run_inc;
                    end else begin
                        locked_nxt   = 1'b0;
                        mismatch_nxt = 1'b1;
                        if (classified) begin
                            xmode_nxt = code;
                            run_nxt   = RUN_W'(1);
                            state_nxt = TRACK;
                        end else begin
                            run_nxt   = '0;
                            state_nxt = FIRST;
                        end
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= EMPTY;
            Xmode    <= 2'b00;
            base     <= '0;
            pred     <= '0;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            run_len  <= '0;
        end else begin
            state    <= state_nxt;
            Xmode    <= xmode_nxt;
            base     <= base_nxt;
            // Built from next-state values so pred tracks base/Xmode in the same cycle.
            pred     <= base_nxt + step_of(xmode_nxt);
            locked   <= locked_nxt;
            mismatch <= mismatch_nxt;
            run_len  <= run_nxt;
        end
    end

endmodule

// File: tb/tb_delta_pattern_detector.sv
// tb/tb_delta_pattern_detector.sv - scoreboard bench for delta_pattern_detector
module tb_delta_pattern_detector;

    localparam int W        = 12;
    localparam int LOCK_CNT = 3;
    localparam int RUN_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             restart = 1'b0;
    logic             sample_vld = 1'b0;
    logic [W-1:0]     sample = '0;
    logic [1:0]       Xmode;
    logic [W-1:0]     base;
    logic [W-1:0]     pred;
    logic             locked;
    logic             mismatch;
    logic [RUN_W-1:0] run_len;

    always #5 clk = ~clk;

    delta_pattern_detector #(.W(W), .LOCK_CNT(LOCK_CNT), .RUN_W(RUN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .sample_vld (sample_vld),
        .sample     (sample),
        .Xmode      (Xmode),
        .base       (base),
        .pred       (pred),
        .locked     (locked),
        .mismatch   (mismatch),
        .run_len    (run_len)
    );

    typedef struct {
        logic [1:0]       xm;
        logic [W-1:0]     base;
        logic [W-1:0]     pred;
        logic             locked;
        logic             mism;
        logic [RUN_W-1:0] run;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: history of accepted samples since the last clear.
    int         hist[$];
    logic [W-1:0] m_base = '0;
    logic [1:0] m_xm = 2'b00;
    int         m_run = 0;
    bit         m_locked = 1'b0;
    bit         m_mism = 1'b0;

    function automatic int cls(input int d);
        int m;
        m = d & ((1 << W) - 1);
        if (m == 0) return 0;
        if (m == 1) return 1;
        if (m == 4) return 2;
        if (m == 8) return 3;
        return -1;
    endfunction

    function automatic int step_val(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    // Length of the trailing run of identical classified deltas.
    function automatic int trail_run();
        int n, c, k;
        n = hist.size();
        if (n < 2) return 0;
        c = cls(hist[n-1] - hist[n-2]);
        if (c < 0) return 0;
        k = 0;
        for (int i = n - 1; i >= 1; i--) begin
            if (cls(hist[i] - hist[i-1]) != c) break;
            k++;
        end
        return k;
    endfunction

    // Most recent classified delta since the last clear, else step 0.
    function automatic logic [1:0] last_code();
        int c;
        for (int i = hist.size() - 1; i >= 1; i--) begin
            c = cls(hist[i] - hist[i-1]);
            if (c >= 0) return 2'(c);
        end
        return 2'b00;
    endfunction

    task automatic drive(input bit r, input bit rs, input bit v, input logic [W-1:0] s);
        exp_t e;
        bit   prev_locked;
        @(negedge clk);
        rst_n      = r;
        restart    = rs;
        sample_vld = v;
        sample     = s;
        if (r) begin
            hist.delete();
            m_base = '0; m_xm = 2'b00; m_run = 0; m_locked = 1'b0; m_mism = 1'b0;
        end else if (rs) begin
            hist.delete();
            m_xm = 2'b00; m_run = 0; m_locked = 1'b0; m_mism = 1'b0;
            if (v) begin
                hist.push_back(int'(s));
                m_base = s;
            end
        end else if (v) begin
            prev_locked = m_locked;
            hist.push_back(int'(s));
            if (hist.size() > 400) void'(hist.pop_front());
            m_base   = s;
            m_run    = trail_run();
            m_xm     = last_code();
            m_locked = (m_run >= LOCK_CNT);
            m_mism   = prev_locked && !m_locked;
        end else begin
            m_mism = 1'b0;
        end
        e.xm     = m_xm;
        e.base   = m_base;
        e.pred   = W'(int'(m_base) + step_val(m_xm));
        e.locked = m_locked;
        e.mism   = m_mism;
        e.run    = (m_run > 255) ? RUN_W'(255) : RUN_W'(m_run);
        sbq.push_back(e);
    endtask

    task automatic feed(input logic [W-1:0] s);
        drive(1'b0, 1'b0, 1'b1, s);
    endtask

    // Monitor: outputs are registered, so every cycle presents one response.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (Xmode !== e.xm || base !== e.base || pred !== e.pred ||
                locked !== e.locked || mismatch !== e.mism || run_len !== e.run) begin
                n_bad++;
                $display("FAIL out_cmp t=%0t got xm=%0d base=%0d pred=%0d lk=%0b mm=%0b run=%0d exp xm=%0d base=%0d pred=%0d lk=%0b mm=%0b run=%0d",
                         $time, Xmode, base, pred, locked, mismatch, run_len,
                         e.xm, e.base, e.pred, e.locked, e.mism, e.run);
            end
        end
    end

    initial begin
        logic [W-1:0] stp;
        int           sel;

        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 12'd55);
        drive(1'b0, 1'b0, 1'b0, '0);

        // Step 1 lock.
        for (int i = 100; i <= 103; i++) feed(W'(i));
        drive(1'b0, 1'b0, 1'b0, '0);

        // Step 4 across wrap.
        drive(1'b0, 1'b1, 1'b0, '0);
        feed(12'd4088); feed(12'd4092); feed(12'd0); feed(12'd4); feed(12'd8);

        // Step 8 lock at 200, then break with unclassified delta and recover.
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 176; i <= 200; i += 8) feed(W'(i));
        feed(12'd205);
        feed(12'd206);
        drive(1'b0, 1'b0, 1'b0, '0);

        // Step 0 with idle gaps.
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, (i % 2) == 0, 12'd50);

        // Restart with sample while locked.
        for (int i = 0; i < 4; i++) feed(12'd50);
        drive(1'b0, 1'b1, 1'b1, 12'd777);
        feed(12'd778);

        // Saturation, then reset mid-run.
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 300; i++) feed(12'd9);
        drive(1'b1, 1'b0, 1'b1, 12'd9);
        feed(12'd9);

        // Randomized phase.
        stp = W'(1);
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 12) begin
                case ($urandom_range(0, 4))
                    0: stp = W'(0);
                    1: stp = W'(1);
                    2: stp = W'(4);
                    3: stp = W'(8);
                    default: stp = W'($urandom_range(0, 4095));
                endcase
            end
            if ($urandom_range(0, 199) == 0)
                drive(1'b1, 1'b0, 1'(($urandom_range(0, 1))), W'($urandom_range(0, 4095)));
            else if ($urandom_range(0, 49) == 0)
                drive(1'b0, 1'b1, 1'(($urandom_range(0, 1))), W'($urandom_range(0, 4095)));
            else if ($urandom_range(0, 99) < 80)
                feed(m_base + stp);
            else
                drive(1'b0, 1'b0, 1'b0, W'($urandom_range(0, 4095)));
        end

        drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
